// File: rtl/ct_idu_dep_src2_issue_sched_if.sv
// ct_idu_dep_src2_issue_sched_if: create, wake-up, issue and flush signals of the src2 scheduler
interface ct_idu_dep_src2_issue_sched_if #(
  parameter int NUM_ENTRY = 8,
  parameter int PREG_W = 7
);
  localparam int IW = $clog2(NUM_ENTRY);
  localparam int CW = $clog2(NUM_ENTRY + 1);
  logic rtu_idu_flush_is;
  logic x_create_vld;
  logic [PREG_W-1:0] x_create_preg;
  logic x_create_rdy;
  logic x_create_ack;
  logic [IW-1:0] x_create_idx;
  logic x_full;
  logic wb_preg_vld;
  logic [PREG_W-1:0] wb_preg;
  logic x_issue_vld;
  logic [IW-1:0] x_issue_idx;
  logic [PREG_W-1:0] x_issue_preg;
  logic x_issue_stall;
  logic [CW-1:0] x_entry_cnt;
  modport master (
    output rtu_idu_flush_is, x_create_vld, x_create_preg, x_create_rdy, wb_preg_vld, wb_preg, x_issue_stall,
    input x_create_ack, x_create_idx, x_full, x_issue_vld, x_issue_idx, x_issue_preg, x_entry_cnt
  );
  modport slave (
    input rtu_idu_flush_is, x_create_vld, x_create_preg, x_create_rdy, wb_preg_vld, wb_preg, x_issue_stall,
    output x_create_ack, x_create_idx, x_full, x_issue_vld, x_issue_idx, x_issue_preg, x_entry_cnt
  );
endinterface

// File: rtl/ct_idu_dep_src2_issue_sched.sv
// ct_idu_dep_src2_issue_sched: source-2 dependency entries with writeback wake-up and round-robin issue
module ct_idu_dep_src2_issue_sched #(
  parameter int NUM_ENTRY = 8,
  parameter int PREG_W = 7
) (
  input logic forever_cpuclk,
  input logic cpurst,
  ct_idu_dep_src2_issue_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_ENTRY);
  localparam int CW = $clog2(NUM_ENTRY + 1);
  logic [NUM_ENTRY-1:0] vld, rdy, cand;
  logic [PREG_W-1:0] preg [NUM_ENTRY];
  logic [IW-1:0] rr_ptr, free_idx, iss_idx;
  logic [CW-1:0] cnt;
  logic full, iss_vld, ack, hs, create_hit;
  assign full = &vld;
  assign cand = vld & rdy;
  assign ack = bus.x_create_vld && !full && !bus.rtu_idu_flush_is;
  assign hs = iss_vld && !bus.x_issue_stall && !bus.rtu_idu_flush_is;
  assign create_hit = bus.x_create_rdy || (bus.wb_preg_vld && bus.wb_preg == bus.x_create_preg);
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--)
      if (!vld[IW'(i)]) free_idx = IW'(i);
  end
  // reverse scan so the candidate nearest above rr_ptr is the last one written
  always_comb begin
    iss_vld = 1'b0;
    iss_idx = '0;
    for (int k = NUM_ENTRY - 1; k >= 0; k--)
      if (cand[rr_ptr + IW'(k)]) begin
        iss_vld = 1'b1;
        iss_idx = rr_ptr + IW'(k);
      end
  end
  for (genvar e = 0; e < NUM_ENTRY; e++) begin : g_ent
    logic v, r;
    logic [PREG_W-1:0] p;
    always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
        v <= 1'b0;
        r <= 1'b0;
        p <= '0;
      end else if (bus.rtu_idu_flush_is || (hs && iss_idx == IW'(e))) begin
        v <= 1'b0;
        r <= 1'b0;
      end else if (ack && free_idx == IW'(e)) begin
        v <= 1'b1;
        r <= create_hit;
        p <= bus.x_create_preg;
      end else if (v && bus.wb_preg_vld && p == bus.wb_preg) begin
        r <= 1'b1;
      end
    end
    assign vld[e] = v;
    assign rdy[e] = r;
    assign preg[e] = p;
  end
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || bus.rtu_idu_flush_is) begin
      rr_ptr <= '0;
      cnt <= '0;
    end else begin
      rr_ptr <= hs ? iss_idx + 1'b1 : rr_ptr;
      cnt <= cnt + CW'(ack) - CW'(hs);
    end
  end
  assign bus.x_create_ack = ack;
  assign bus.x_create_idx = free_idx;
  assign bus.x_full = full;
  assign bus.x_issue_vld = iss_vld;
  assign bus.x_issue_idx = iss_idx;
  assign bus.x_issue_preg = iss_vld ? preg[iss_idx] : '0;
  assign bus.x_entry_cnt = cnt;
endmodule
